// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the hazard controller: opcodes, field
// positions and the {wr, dest} scoreboard entry.
package pipeline_hazard_controller_pkg;

  localparam int INSTR_W = 20;
  localparam int FIELD_W = 4;

  localparam int OPC_LSB = 16;
  localparam int RD_LSB  = 12;
  localparam int RA_LSB  = 8;
  localparam int RB_LSB  = 4;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b1100;

  typedef struct packed {
    logic       wr;
    logic [3:0] dest;
  } sb_entry_t;

endpackage

// File: rtl/pipeline_hazard_controller_reg_field_decode.sv
// Register-field decoder: instruction -> source regs, use flags,
// write flag and destination. Purely combinational.
module reg_field_decode
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [INSTR_W-1:0] instruction,
  output logic [3:0]         src1,
  output logic [3:0]         src2,
  output logic               src1_used,
  output logic               src2_used,
  output logic               wr,
  output logic [3:0]         dest
);

  logic [3:0] opcode;
  logic [3:0] f_rd;
  logic [3:0] f_a;
  logic [3:0] f_b;
  logic [3:0] unused_low;

  assign opcode     = instruction[OPC_LSB +: FIELD_W];
  assign f_rd       = instruction[RD_LSB +: FIELD_W];
  assign f_a        = instruction[RA_LSB +: FIELD_W];
  assign f_b        = instruction[RB_LSB +: FIELD_W];
  assign unused_low = instruction[3:0];
  assign dest       = f_rd;

  always_comb begin
    src1      = f_a;
    src2      = f_b;
    src1_used = 1'b0;
    src2_used = 1'b0;
    wr        = 1'b0;
    unique case (1'b1)
      (opcode == OP_NOP): begin
      end
      // Stores read their address register from the rd slot.
      (opcode == OP_STORE): begin
        src1      = f_rd;
        src2      = f_a;
        src1_used = 1'b1;
        src2_used = 1'b1;
      end
      default: begin
        src1_used = 1'b1;
        src2_used = 1'b1;
        wr        = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// RAW hazard detection and ID/EX issue control.
// In: clock, reset, id_valid, id_instruction, flush.
// Out: stall, ex_instruction, ex_valid, stall_count.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [INSTR_W-1:0] id_instruction,
  input  logic               flush,
  output logic               stall,
  output logic [INSTR_W-1:0] ex_instruction,
  output logic               ex_valid,
  output logic [CNT_W-1:0]   stall_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sb_entry_t sb [PIPE_DEPTH];

  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_src1_used;
  logic       id_src2_used;
  logic       unused_id_wr;
  logic [3:0] unused_id_dest;

  logic [3:0] unused_iss_src1;
  logic [3:0] unused_iss_src2;
  logic       unused_iss_src1_used;
  logic       unused_iss_src2_used;
  logic       iss_wr;
  logic [3:0] iss_dest;

  logic               hazard;
  logic               live;
  logic               issue;
  logic [INSTR_W-1:0] iss_instr;

  reg_field_decode u_id_dec (
    .instruction (id_instruction),
    .src1        (id_src1),
    .src2        (id_src2),
    .src1_used   (id_src1_used),
    .src2_used   (id_src2_used),
    .wr          (unused_id_wr),
    .dest        (unused_id_dest)
  );

  // A bubble is all-zero, i.e. a NOP, so it decodes to wr = 0.
  assign iss_instr = issue ? id_instruction : '0;

  reg_field_decode u_iss_dec (
    .instruction (iss_instr),
    .src1        (unused_iss_src1),
    .src2        (unused_iss_src2),
    .src1_used   (unused_iss_src1_used),
    .src2_used   (unused_iss_src2_used),
    .wr          (iss_wr),
    .dest        (iss_dest)
  );

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (sb[i].wr &&
          ((id_src1_used && sb[i].dest == id_src1) ||
           (id_src2_used && sb[i].dest == id_src2)))
        hazard = 1'b1;
    end
  end

  // Flush overrides a pending hazard: no stall, bubble issued.
  assign live  = id_valid && !flush;
  assign stall = live && hazard;
  assign issue = live && !hazard;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++)
        sb[i] <= '0;
      ex_instruction <= '0;
      ex_valid       <= 1'b0;
      stall_count    <= '0;
    end else begin
      sb[0] <= '{wr: iss_wr, dest: iss_dest};
      for (int i = 1; i < PIPE_DEPTH; i++)
        sb[i] <= sb[i-1];
      ex_instruction <= iss_instr;
      ex_valid       <= issue;
      if (stall && stall_count != CNT_MAX)
        stall_count <= stall_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; a second
// instance with a 4-bit counter checks saturation.
module tb_pipeline_hazard_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [19:0] id_instruction = '0;
  logic        flush = 1'b0;

  logic        stall;
  logic [19:0] ex_instruction;
  logic        ex_valid;
  logic [15:0] stall_count;

  logic        stall4;
  logic [19:0] ex_instruction4;
  logic        ex_valid4;
  logic [3:0]  stall_count4;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  always #5 clock = ~clock;

  pipeline_hazard_controller dut (
    .clock          (clock),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .flush          (flush),
    .stall          (stall),
    .ex_instruction (ex_instruction),
    .ex_valid       (ex_valid),
    .stall_count    (stall_count)
  );

  pipeline_hazard_controller #(.PIPE_DEPTH(3), .CNT_W(4)) dut_sat (
    .clock          (clock),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .flush          (flush),
    .stall          (stall4),
    .ex_instruction (ex_instruction4),
    .ex_valid       (ex_valid4),
    .stall_count    (stall_count4)
  );

  task automatic clk();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input logic v, input logic [19:0] ins,
                       input logic f);
    id_valid       = v;
    id_instruction = ins;
    flush          = f;
    #1;
  endtask

  task automatic idle(input int n);
    apply(1'b0, 20'h0, 1'b0);
    repeat (n) clk();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) clk();
    checks++;
    if (stall !== 1'b0 || ex_valid !== 1'b0 ||
        ex_instruction !== 20'h0 || stall_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_state got stall=%b v=%b ins=%h cnt=%0d exp 0/0/0/0",
               stall, ex_valid, ex_instruction, stall_count);
    end
    reset = 1'b0;
    exp_cnt = 0;
    clk();
  endtask

  task automatic test_dependent();
    idle(3);
    apply(1'b1, 20'h11230, 1'b0);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL dep_producer_stall got=%b exp=0", stall);
    end
    clk();
    checks++;
    if (ex_valid !== 1'b1 || ex_instruction !== 20'h11230) begin
      failures++;
      $display("FAIL dep_issue got v=%b ins=%h exp v=1 ins=11230",
               ex_valid, ex_instruction);
    end
    apply(1'b1, 20'h12140, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (stall !== 1'b1) begin
        failures++;
        $display("FAIL dep_stall_%0d got=%b exp=1", k, stall);
      end
      exp_cnt++;
      clk();
      checks++;
      if (ex_valid !== 1'b0 || ex_instruction !== 20'h0) begin
        failures++;
        $display("FAIL dep_bubble_%0d got v=%b ins=%h exp v=0 ins=0",
                 k, ex_valid, ex_instruction);
      end
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL dep_release got=%b exp=0", stall);
    end
    clk();
    checks++;
    if (ex_valid !== 1'b1 || ex_instruction !== 20'h12140) begin
      failures++;
      $display("FAIL dep_consumer got v=%b ins=%h exp v=1 ins=12140",
               ex_valid, ex_instruction);
    end
    checks++;
    if (stall_count !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL dep_count got=%0d exp=%0d", stall_count, exp_cnt);
    end
  endtask

  task automatic test_store();
    idle(3);
    apply(1'b1, 20'h1F230, 1'b0);
    clk();
    apply(1'b1, 20'hC0F00, 1'b0);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL store_src_a got=%b exp=1", stall);
    end
    exp_cnt++;
    clk();
    idle(3);
    apply(1'b1, 20'h10230, 1'b0);
    clk();
    apply(1'b1, 20'hC0F00, 1'b0);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL store_src_rd got=%b exp=1", stall);
    end
    exp_cnt++;
    clk();
    idle(3);
    apply(1'b1, 20'hC1230, 1'b0);
    clk();
    apply(1'b1, 20'h13120, 1'b0);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL store_producer got=%b exp=0", stall);
    end
    clk();
    checks++;
    if (ex_instruction !== 20'h13120 || ex_valid !== 1'b1) begin
      failures++;
      $display("FAIL store_follow_issue got v=%b ins=%h exp v=1 ins=13120",
               ex_valid, ex_instruction);
    end
    checks++;
    if (stall_count !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL store_count got=%0d exp=%0d", stall_count, exp_cnt);
    end
  endtask

  task automatic test_independent();
    idle(3);
    apply(1'b1, 20'h17230, 1'b0); clk();
    apply(1'b1, 20'h18230, 1'b0); clk();
    apply(1'b1, 20'h19230, 1'b0); clk();
    apply(1'b1, 20'h1A700, 1'b0);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL gap2_stall got=%b exp=1", stall);
    end
    exp_cnt++;
    clk();
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL gap2_release got=%b exp=0", stall);
    end
    clk();
    checks++;
    if (ex_instruction !== 20'h1A700) begin
      failures++;
      $display("FAIL gap2_issue got=%h exp=1a700", ex_instruction);
    end
    idle(3);
    apply(1'b1, 20'h17230, 1'b0); clk();
    apply(1'b1, 20'h18230, 1'b0); clk();
    apply(1'b1, 20'h19230, 1'b0); clk();
    apply(1'b1, 20'h1B230, 1'b0); clk();
    apply(1'b1, 20'h1A700, 1'b0);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL gap3_stall got=%b exp=0", stall);
    end
    clk();
    checks++;
    if (ex_instruction !== 20'h1A700 || ex_valid !== 1'b1) begin
      failures++;
      $display("FAIL gap3_issue got v=%b ins=%h exp v=1 ins=1a700",
               ex_valid, ex_instruction);
    end
  endtask

  task automatic test_flush();
    idle(3);
    apply(1'b1, 20'h15230, 1'b0);
    clk();
    apply(1'b1, 20'h16500, 1'b1);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall got=%b exp=0", stall);
    end
    clk();
    checks++;
    if (ex_valid !== 1'b0 || ex_instruction !== 20'h0 ||
        stall_count !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL flush_bubble got v=%b ins=%h cnt=%0d exp v=0 ins=0 cnt=%0d",
               ex_valid, ex_instruction, stall_count, exp_cnt);
    end
    apply(1'b1, 20'h16500, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stall !== 1'b1) begin
        failures++;
        $display("FAIL flush_after_%0d got=%b exp=1", k, stall);
      end
      exp_cnt++;
      clk();
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_after_release got=%b exp=0", stall);
    end
    clk();
    checks++;
    if (ex_instruction !== 20'h16500) begin
      failures++;
      $display("FAIL flush_after_issue got=%h exp=16500", ex_instruction);
    end
  endtask

  task automatic test_saturation();
    int e4;
    idle(3);
    apply(1'b1, 20'h11110, 1'b0);
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (stall !== (c % 4 != 0)) begin
        failures++;
        $display("FAIL chain_stall_%0d got=%b exp=%b", c, stall, (c % 4 != 0));
      end
      if (c % 4 != 0) exp_cnt++;
      clk();
    end
    idle(2);
    e4 = (exp_cnt > 15) ? 15 : exp_cnt;
    checks++;
    if (stall_count4 !== 4'(e4)) begin
      failures++;
      $display("FAIL sat_count4 got=%0d exp=%0d", stall_count4, e4);
    end
    checks++;
    if (stall_count !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL sat_count16 got=%0d exp=%0d", stall_count, exp_cnt);
    end
    apply(1'b1, 20'h11110, 1'b0); clk();
    apply(1'b1, 20'h11110, 1'b0); clk();
    exp_cnt++;
    idle(3);
    checks++;
    if (stall_count4 !== 4'd15) begin
      failures++;
      $display("FAIL sat_hold got=%0d exp=15", stall_count4);
    end
  endtask

  task automatic test_reset_mid_stall();
    idle(3);
    apply(1'b1, 20'h11230, 1'b0);
    clk();
    apply(1'b1, 20'h12140, 1'b0);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_stall got=%b exp=1", stall);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || ex_valid !== 1'b0 || ex_instruction !== 20'h0 ||
        stall_count !== 16'd0 || stall_count4 !== 4'd0) begin
      failures++;
      $display("FAIL rst_async got stall=%b v=%b ins=%h cnt=%0d cnt4=%0d exp all 0",
               stall, ex_valid, ex_instruction, stall_count, stall_count4);
    end
    clk();
    reset = 1'b0;
    exp_cnt = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_release_stall got=%b exp=0", stall);
    end
    clk();
    checks++;
    if (ex_instruction !== 20'h12140 || stall_count !== 16'd0) begin
      failures++;
      $display("FAIL rst_release_issue got ins=%h cnt=%0d exp ins=12140 cnt=0",
               ex_instruction, stall_count);
    end
  endtask

  initial begin
    test_reset();
    test_dependent();
    test_store();
    test_independent();
    test_flush();
    test_saturation();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
